// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared state encoding and register constants for the hazard controller.
package hazard_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// hazard_ctrl_load_use_detect: flags a load in EX whose destination is read by the instruction in ID.
module hazard_ctrl_load_use_detect
  import hazard_ctrl_pkg::*;
(
  input  logic       idex_memread,
  input  logic [4:0] idex_rt,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  output logic       lu_hazard
);
  assign lu_hazard = idex_memread & (idex_rt != REG_ZERO) & ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID/EX sequencing FSM (load-use stall, branch flush, external hold).
// Optional saturating stall/flush statistics when HAZARD_STATS_EN is defined.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic             branch_taken,
  input  logic             ext_stall_req,
  output logic             ext_stall_ack,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       state_o
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
`endif
);
  state_t     state_q;
  logic [3:0] cnt_q;
  logic       pend_q;
  logic       lu_hazard;
  logic       in_run, flush_go, run_free;
  hazard_ctrl_load_use_detect u_lud (
    .idex_memread(idex_memread),
    .idex_rt     (idex_rt),
    .ifid_rs     (ifid_rs),
    .ifid_rt     (ifid_rt),
    .lu_hazard   (lu_hazard)
  );
  always_comb begin
    in_run        = state_q == ST_RUN;
    flush_go      = in_run & (branch_taken | pend_q);
    run_free      = in_run & ~flush_go & ~ext_stall_req & ~lu_hazard;
    ifid_flush    = ~reset & (flush_go | (state_q == ST_FLUSH));
    pc_write      = ~reset & (ifid_flush | run_free);
    ifid_write    = pc_write;
    idex_bubble   = reset | ~run_free;
    ext_stall_ack = ~reset & (state_q == ST_HOLD);
    state_o       = state_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (flush_go) begin
            pend_q <= 1'b0;
            if (FLUSH_CYCLES > 1) begin
              state_q <= ST_FLUSH;
              cnt_q   <= 4'(FLUSH_CYCLES - 1);
            end
          end else if (ext_stall_req) state_q <= ST_HOLD;
        end
        ST_FLUSH: begin
          cnt_q   <= cnt_q - 4'd1;
          state_q <= (cnt_q == 4'd1) ? ST_RUN : ST_FLUSH;
        end
        ST_HOLD: begin
          pend_q  <= pend_q | branch_taken;
          state_q <= ext_stall_req ? ST_HOLD : ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (idex_bubble & ~ifid_flush & ~&stall_q) stall_q <= stall_q + 1'b1;
      if (ifid_flush & ~&flush_q) flush_q <= flush_q + 1'b1;
    end
  end
  assign stall_cycles = stall_q;
  assign flush_cycles = flush_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random stimulus on two configurations (3-cycle and 1-cycle flush)
// against a counter-based reference model.
module tb_hazard_ctrl;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] ifid_rs = '0, ifid_rt = '0, idex_rt = '0;
  logic       idex_memread = 1'b0, branch_taken = 1'b0, ext_stall_req = 1'b0;
  logic       ack [2], pcw [2], ifw [2], flu [2], bub [2];
  logic [1:0] st [2];
  logic [31:0] sc [2], fc [2];
  int n_chk = 0, n_fail = 0;
  int fl [2], m_st [2], m_fc [2];
  bit hold [2], pend [2];
  int flen [2] = '{3, 1};
  int flush_seen;
  always #5 clock = ~clock;
  for (genvar k = 0; k < 2; k++) begin : g_dut
    hazard_ctrl #(.FLUSH_CYCLES(k == 0 ? 3 : 1), .CNT_W(32)) dut (
      .clock(clock), .reset(reset), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
      .idex_memread(idex_memread), .idex_rt(idex_rt), .branch_taken(branch_taken),
      .ext_stall_req(ext_stall_req), .ext_stall_ack(ack[k]), .pc_write(pcw[k]),
      .ifid_write(ifw[k]), .ifid_flush(flu[k]), .idex_bubble(bub[k]), .state_o(st[k])
`ifdef HAZARD_STATS_EN
      , .stall_cycles(sc[k]), .flush_cycles(fc[k])
`endif
    );
`ifndef HAZARD_STATS_EN
    assign sc[k] = '0;
    assign fc[k] = '0;
`endif
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Drive one cycle, compare every output against the model, then advance the model.
  task automatic cyc(input logic r, br, req, mr, input logic [4:0] rt, rs, rtt);
    logic [6:0] exp;
    bit lu;
    @(negedge clock);
    reset = r; branch_taken = br; ext_stall_req = req; idex_memread = mr;
    idex_rt = rt; ifid_rs = rs; ifid_rt = rtt;
    #1;
    lu = mr && rt != 0 && (rt == rs || rt == rtt);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        exp = 7'b00_0_0_0_0_1; fl[k] = 0; hold[k] = 0; pend[k] = 0; m_st[k] = 0; m_fc[k] = 0;
      end else if (fl[k] > 0) begin
        exp = 7'b01_0_1_1_1_1; fl[k]--;
      end else if (hold[k]) begin
        exp = 7'b10_1_0_0_0_1; pend[k] |= br; hold[k] = req;
      end else if (br || pend[k]) begin
        exp = 7'b00_0_1_1_1_1; pend[k] = 0; fl[k] = flen[k] - 1;
      end else if (req) begin
        exp = 7'b00_0_0_0_0_1; hold[k] = 1;
      end else if (lu) exp = 7'b00_0_0_0_0_1;
      else exp = 7'b00_0_1_1_0_0;
      check(k == 0 ? "outs_f3" : "outs_f1", {25'd0, st[k], ack[k], pcw[k], ifw[k], flu[k], bub[k]}, {25'd0, exp});
`ifdef HAZARD_STATS_EN
      check(k == 0 ? "stall_f3" : "stall_f1", sc[k], m_st[k]);
      check(k == 0 ? "flcnt_f3" : "flcnt_f1", fc[k], m_fc[k]);
`endif
      if (!r) begin
        m_st[k] += (exp[0] && !exp[1]) ? 1 : 0;
        m_fc[k] += exp[1] ? 1 : 0;
      end
    end
  endtask
  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    // reset aborts a hold
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    check("hold_ack", {31'd0, ack[0]}, 1);
    cyc(1, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("rst_state", {30'd0, st[0]}, 0);
    check("rst_pcw", {31'd0, pcw[0]}, 1);
    // load-use one-cycle stall, then r0 is never a hazard
    cyc(0, 0, 0, 1, 8, 8, 3);
    check("lu_pcw", {31'd0, pcw[1]}, 0);
    cyc(0, 0, 0, 0, 8, 8, 3);
    cyc(0, 0, 0, 1, 0, 4, 0);
    check("r0_bub", {31'd0, bub[1]}, 0);
    // branch flush length
    flush_seen = 0;
    cyc(0, 1, 0, 0, 0, 0, 0);
    flush_seen += flu[0];
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      flush_seen += flu[0];
    end
    check("flush_len_f3", flush_seen, 3);
    // branch during hold becomes a pending flush
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("pend_flush", {31'd0, flu[1]}, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    // one load-use plus one branch from reset
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 5, 2, 5);
    cyc(0, 0, 0, 0, 5, 2, 5);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_STATS_EN
    check("t6_stall", sc[1], 1);
    check("t6_flush", fc[1], 1);
`endif
    begin
      logic req = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 4) == 0) req = ~req;
        cyc($urandom_range(0, 99) == 0, $urandom_range(0, 6) == 0, req, 1'($urandom),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
